// File: rtl/lut_pkg.sv
// Shared types and default table for the programmable lookup table.
// The default contents live here and are reached only through default_val().
package lut_pkg;

    typedef enum logic {
        INIT,
        IDLE
    } state_t;

    localparam int NUM_DEFAULTS = 6;
    localparam int MAX_W        = 64;

    localparam logic signed [7:0] DEFAULTS [NUM_DEFAULTS] = '{
        -8'sd11, 8'sd9, -8'sd20, 8'sd14, 8'sd3, 8'sd17
    };

    // Sign-extend the 8-bit default for idx to w bits; entries past the table are zero.
    function automatic logic [MAX_W-1:0] default_val(input int unsigned idx, input int unsigned w);
        logic [7:0]       raw;
        logic [MAX_W-1:0] ext;
        raw = (idx < NUM_DEFAULTS) ? DEFAULTS[idx[2:0]] : 8'h00;
        ext = {{(MAX_W-8){raw[7]}}, raw};
        if (w < MAX_W) begin
            ext = ext & ((64'd1 << w) - 64'd1);
        end
        return ext;
    endfunction

endpackage

// File: rtl/lut_defaults.sv
// Combinational default ROM: maps an entry index to its W-bit reset value.
module lut_defaults
    import lut_pkg::*;
#(
    parameter int W     = 8,
    parameter int IDX_W = 6
) (
    input  logic [IDX_W-1:0] idx,
    output logic [W-1:0]     value
);

    always_comb begin
        value = W'(default_val(32'(idx), W));
    end

endmodule

// File: rtl/lut_prog.sv
// Run-time programmable lookup table with registered reads and a restore
// sequencer that rewrites the default contents one entry per cycle.
module lut_prog
    import lut_pkg::*;
#(
    parameter int W     = 8,
    parameter int PTR_W = 5,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_en,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic [W-1:0]     rd_data,
    output logic             rd_valid,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [W-1:0]     wr_data,
    input  logic             restore,
    output logic             busy
);

    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DEPTH - 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [W-1:0]       mem_reg [DEPTH];
    logic [W-1:0]       rd_data_reg, rd_data_next;
    logic               rd_valid_reg;
    logic [W-1:0]       def_value;
    logic [W-1:0]       entry_wdata;
    logic [DEPTH-1:0]   entry_we;
    logic               in_init, rd_ptr_ok, wr_ptr_ok, sw_wr, rd_accept;

    lut_defaults #(
        .W     (W),
        .IDX_W (CNT_W)
    ) u_defaults (
        .idx   (cnt_reg),
        .value (def_value)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        busy       = 1'b0;
        case (state_reg)
            INIT: begin
                busy = 1'b1;
                if (cnt_reg == LAST_CNT) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            IDLE: begin
                if (restore) begin
                    state_next = INIT;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = INIT;
                cnt_next   = '0;
            end
        endcase
    end

    assign in_init   = (state_reg == INIT);
    assign rd_ptr_ok = ({1'b0, rd_ptr} < DEPTH_C);
    assign wr_ptr_ok = ({1'b0, wr_ptr} < DEPTH_C);
    // A restore request wins over a software write in the same cycle.
    assign sw_wr     = !in_init && wr_en && !restore && wr_ptr_ok;
    assign rd_accept = !in_init && rd_en;
    assign entry_wdata = in_init ? def_value : wr_data;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
        assign entry_we[gi] = in_init ? (cnt_reg == CNT_W'(gi))
                                      : (sw_wr && (wr_ptr == PTR_W'(gi)));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_we[i]) begin
                    mem_reg[i] <= entry_wdata;
                end
            end
        end
    end

    // Write-through so a same-cycle read of the written entry sees the new value.
    always_comb begin
        rd_data_next = '0;
        if (rd_ptr_ok) begin
            if (sw_wr && (wr_ptr == rd_ptr)) begin
                rd_data_next = wr_data;
            end else begin
                rd_data_next = mem_reg[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_accept;
            if (rd_accept) begin
                rd_data_reg <= rd_data_next;
            end
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_lut_prog.sv
// Scoreboarded bench for lut_prog: three instances (base, DEPTH=24, W=16)
// share stimulus; a cycle model predicts busy, rd_valid and rd_data.
module tb_lut_prog;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_en;
    logic [4:0]  rd_ptr;
    logic        wr_en;
    logic [4:0]  wr_ptr;
    logic [15:0] wr_data;
    logic        restore;

    logic [7:0]  d0, d1;
    logic [15:0] d2;
    logic        v0, v1, v2, b0, b1, b2;
    logic [7:0]  wr_data8;

    logic [15:0] data_o  [3];
    logic        valid_o [3];
    logic        busy_o  [3];

    always #5 clk = ~clk;

    assign wr_data8 = wr_data[7:0];

    lut_prog #(.W(8), .PTR_W(5), .DEPTH(32)) u_base (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_ptr(rd_ptr), .rd_data(d0),
        .rd_valid(v0), .wr_en(wr_en), .wr_ptr(wr_ptr), .wr_data(wr_data8),
        .restore(restore), .busy(b0)
    );

    lut_prog #(.W(8), .PTR_W(5), .DEPTH(24)) u_d24 (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_ptr(rd_ptr), .rd_data(d1),
        .rd_valid(v1), .wr_en(wr_en), .wr_ptr(wr_ptr), .wr_data(wr_data8),
        .restore(restore), .busy(b1)
    );

    lut_prog #(.W(16), .PTR_W(5), .DEPTH(32)) u_w16 (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_ptr(rd_ptr), .rd_data(d2),
        .rd_valid(v2), .wr_en(wr_en), .wr_ptr(wr_ptr), .wr_data(wr_data),
        .restore(restore), .busy(b2)
    );

    assign data_o[0]  = {8'h00, d0};
    assign data_o[1]  = {8'h00, d1};
    assign data_o[2]  = d2;
    assign valid_o[0] = v0;
    assign valid_o[1] = v1;
    assign valid_o[2] = v2;
    assign busy_o[0]  = b0;
    assign busy_o[1]  = b1;
    assign busy_o[2]  = b2;

    int total = 0;
    int bad   = 0;

    int          depth_m [3] = '{32, 24, 32};
    logic [15:0] mask_m  [3] = '{16'h00FF, 16'h00FF, 16'hFFFF};
    int          def_tab [6] = '{-11, 9, -20, 14, 3, 17};

    bit          busy_m [3];
    int          cnt_m  [3];
    logic [15:0] last_m [3];
    logic [15:0] mem_m  [3][32];
    logic [15:0] q0[$], q1[$], q2[$];

    function automatic logic [15:0] def_of(int inst, int idx);
        logic [15:0] v;
        v = (idx < 6) ? 16'(def_tab[idx]) : 16'h0000;
        return v & mask_m[inst];
    endfunction

    task automatic chk(string tag, int inst, logic [15:0] obs, logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[u%0d] observed=%h expected=%h", tag, inst, obs, exp);
        end
    endtask

    task automatic push(int inst, logic [15:0] v);
        case (inst)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    // Cycle model, evaluated with the input values present at the rising edge.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                busy_m[i] = 1'b1;
                cnt_m[i]  = 0;
                last_m[i] = 16'h0000;
            end else if (busy_m[i]) begin
                mem_m[i][cnt_m[i]] = def_of(i, cnt_m[i]);
                cnt_m[i]++;
                if (cnt_m[i] == depth_m[i]) begin
                    busy_m[i] = 1'b0;
                    cnt_m[i]  = 0;
                end
            end else begin
                if (!restore && wr_en && (int'(wr_ptr) < depth_m[i]))
                    mem_m[i][wr_ptr] = wr_data & mask_m[i];
                if (rd_en)
                    push(i, (int'(rd_ptr) < depth_m[i]) ? mem_m[i][rd_ptr] : 16'h0000);
                if (restore) begin
                    busy_m[i] = 1'b1;
                    cnt_m[i]  = 0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        bit          have;
        logic [15:0] e;
        for (int i = 0; i < 3; i++) begin
            have = 1'b0;
            e    = 16'h0000;
            case (i)
                0: if (q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
                1: if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
                default: if (q2.size() > 0) begin have = 1'b1; e = q2.pop_front(); end
            endcase
            chk("busy", i, 16'(busy_o[i]), 16'(busy_m[i]));
            chk("rd_valid", i, 16'(valid_o[i]), 16'(have));
            if (have) last_m[i] = e;
            chk("rd_data", i, data_o[i], last_m[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic read_chk(int ptr, logic [15:0] e0, logic [15:0] e1, logic [15:0] e2);
        rd_en  = 1'b1;
        rd_ptr = 5'(ptr);
        tick();
        rd_en  = 1'b0;
        chk("dir_valid", 0, 16'(v0), 16'h0001);
        chk("dir_data", 0, data_o[0], e0);
        chk("dir_data", 1, data_o[1], e1);
        chk("dir_data", 2, data_o[2], e2);
        $display("read ptr=%0d data=%h/%h/%h valid=%b%b%b", ptr, d0, d1, d2, v0, v1, v2);
    endtask

    task automatic write(int ptr, logic [15:0] val);
        wr_en   = 1'b1;
        wr_ptr  = 5'(ptr);
        wr_data = val;
        tick();
        wr_en   = 1'b0;
        $display("write ptr=%0d data=%h", ptr, val);
    endtask

    // Ticks until the base instance drops busy; also notes when the DEPTH=24 copy drops.
    task automatic measure_busy(output int n, output int n24);
        n   = 0;
        n24 = 0;
        do begin
            tick();
            n++;
            if (n24 == 0 && busy_o[1] === 1'b0) n24 = n;
        end while (busy_o[0] === 1'b1 && n < 100);
    endtask

    int n, n24;

    initial begin
        reset   = 1'b1;
        rd_en   = 1'b0;
        rd_ptr  = '0;
        wr_en   = 1'b0;
        wr_ptr  = '0;
        wr_data = '0;
        restore = 1'b0;
        for (int i = 0; i < 3; i++) begin
            busy_m[i] = 1'b1;
            cnt_m[i]  = 0;
            last_m[i] = 16'h0000;
            for (int j = 0; j < 32; j++) mem_m[i][j] = 16'h0000;
        end

        tick();
        tick();
        reset = 1'b0;
        measure_busy(n, n24);
        chk("busy_len_reset", 0, 16'(n), 16'd32);
        chk("busy_len_reset", 1, 16'(n24), 16'd24);
        $display("reset release busy cycles=%0d/%0d", n, n24);

        read_chk(0, 16'h00F5, 16'h00F5, 16'hFFF5);
        read_chk(2, 16'h00EC, 16'h00EC, 16'hFFEC);
        read_chk(5, 16'h0011, 16'h0011, 16'h0011);
        read_chk(9, 16'h0000, 16'h0000, 16'h0000);
        read_chk(1, 16'h0009, 16'h0009, 16'h0009);
        tick();

        write(3, 16'h0040);
        read_chk(3, 16'h0040, 16'h0040, 16'h0040);

        restore = 1'b1;
        tick();
        restore = 1'b0;
        chk("busy_after_restore", 0, 16'(b0), 16'h0001);
        measure_busy(n, n24);
        chk("busy_len_restore", 0, 16'(n), 16'd32);
        read_chk(3, 16'h000E, 16'h000E, 16'h000E);

        // Restore with a same-cycle write and read: write dropped, read served.
        restore = 1'b1;
        wr_en   = 1'b1;
        wr_ptr  = 5'd5;
        wr_data = 16'h0055;
        read_chk(5, 16'h0011, 16'h0011, 16'h0011);
        restore = 1'b0;
        wr_en   = 1'b0;
        measure_busy(n, n24);
        read_chk(5, 16'h0011, 16'h0011, 16'h0011);

        wr_en   = 1'b1;
        wr_ptr  = 5'd4;
        wr_data = 16'h007F;
        read_chk(4, 16'h007F, 16'h007F, 16'h007F);
        wr_en   = 1'b0;
        read_chk(4, 16'h007F, 16'h007F, 16'h007F);

        // Reset in the middle of INIT restarts the sequence; reads during busy are ignored.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        rd_en  = 1'b1;
        rd_ptr = 5'd2;
        measure_busy(n, n24);
        rd_en  = 1'b0;
        chk("busy_len_rerun", 0, 16'(n), 16'd32);
        chk("rd_data_during_busy", 0, data_o[0], 16'h0000);
        $display("reset mid-init busy cycles=%0d", n);
        tick();

        read_chk(30, 16'h0000, 16'h0000, 16'h0000);
        write(30, 16'h00AA);
        read_chk(30, 16'h00AA, 16'h0000, 16'h00AA);

        rd_en = 1'b1;
        for (int p = 0; p < 24; p++) begin
            rd_ptr = 5'(p);
            tick();
            $display("scan ptr=%0d data=%h/%h/%h", p, d0, d1, d2);
        end
        rd_en = 1'b0;
        tick();
        chk("valid_drop", 1, 16'(v1), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
